// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM states, bus widths,
// requester IDs and the byte-merge helper used by partial-word stores.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned SRAM_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_TURN,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_ACK
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_t;

  // Replace the bytes of rd_word selected by be with the bytes of wr_word.
  function automatic logic [SRAM_DW-1:0] merge_be(
    input logic [SRAM_DW-1:0] rd_word,
    input logic [SRAM_DW-1:0] wr_word,
    input logic [3:0]         be
  );
    logic [SRAM_DW-1:0] m;
    m = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wr_word[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both ports contend.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_t r_ptr;

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_ptr == PORT_LS) ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ptr <= PORT_LS;
    end else if (advance && (req == 2'b11)) begin
      r_ptr <= (r_ptr == PORT_LS) ? PORT_IF : PORT_LS;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Shares one asynchronous 32-bit SRAM between the fetch and load/store ports;
// sequences oe/we strobes and turns partial stores into read-modify-write.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                if_req,
  input  logic [SRAM_AW-1:0]  if_addr,
  output logic                if_ack,
  output logic [SRAM_DW-1:0]  if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [3:0]          ls_be,
  input  logic [SRAM_AW-1:0]  ls_addr,
  input  logic [SRAM_DW-1:0]  ls_wdata,
  output logic                ls_ack,
  output logic [SRAM_DW-1:0]  ls_rdata,
  output logic [SRAM_AW-1:0]  sram_addr,
  inout  logic [SRAM_DW-1:0]  sram_data,
  output logic                sram_oe_l,
  output logic                sram_we_l
);

  localparam int unsigned MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
  localparam logic [SRAM_AW-1:0] ADDR_MASK = ~SRAM_AW'(3);

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  port_t              r_port, w_port_next;
  logic               r_rmw, w_rmw_sel;
  logic [3:0]         r_be;
  logic [SRAM_DW-1:0] r_wbuf;
  logic [SRAM_AW-1:0] r_addr;
  logic               r_oe_l, r_we_l, r_drive;
  logic               r_if_ack, r_ls_ack;
  logic [SRAM_DW-1:0] r_if_rdata, r_ls_rdata;

  logic [1:0]         w_gnt;
  logic               w_grant;
  port_t              w_gnt_port;
  logic [SRAM_AW-1:0] w_sel_addr;
  logic               w_sel_we;
  logic [3:0]         w_sel_be;
  logic               w_rd_done;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_l   (rst_l),
    .req     ({ls_req, if_req}),
    .advance (r_state == ST_IDLE),
    .gnt     (w_gnt)
  );

  assign w_grant    = (r_state == ST_IDLE) && (|w_gnt);
  assign w_gnt_port = w_gnt[1] ? PORT_LS : PORT_IF;
  assign w_sel_addr = w_gnt[1] ? ls_addr : if_addr;
  assign w_sel_we   = w_gnt[1] && ls_we;
  assign w_sel_be   = ls_be;
  assign w_rmw_sel  = w_sel_we && (w_sel_be != 4'hF) && (w_sel_be != 4'h0);
  assign w_rd_done  = (r_state == ST_RD) && (r_cnt == RD_LAST);

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_port_next = w_grant ? w_gnt_port : r_port;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_grant) begin
          if (!w_sel_we)               w_next = ST_RD;
          else if (w_sel_be == 4'hF)   w_next = ST_WR_SETUP;
          else if (w_sel_be == 4'h0)   w_next = ST_ACK;
          else                         w_next = ST_RD;
        end
      end
      ST_RD: begin
        if (r_cnt == RD_LAST) begin
          w_cnt_next = '0;
          w_next     = r_rmw ? ST_TURN : ST_ACK;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_TURN:     w_next = ST_WR_SETUP;
      ST_WR_SETUP: begin
        w_cnt_next = '0;
        w_next     = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (r_cnt == WR_LAST) begin
          w_cnt_next = '0;
          w_next     = ST_WR_HOLD;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WR_HOLD:  w_next = ST_ACK;
      ST_ACK:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_port  <= PORT_LS;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_port  <= w_port_next;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rmw      <= 1'b0;
      r_be       <= '0;
      r_wbuf     <= '0;
      r_addr     <= '0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_rmw  <= w_rmw_sel;
        r_be   <= w_sel_be;
        r_wbuf <= ls_wdata;
        r_addr <= w_sel_addr & ADDR_MASK;
      end
      if (w_rd_done) begin
        if (r_rmw)                 r_wbuf     <= merge_be(sram_data, r_wbuf, r_be);
        else if (r_port == PORT_LS) r_ls_rdata <= sram_data;
        else                       r_if_rdata <= sram_data;
      end
    end
  end

  // Strobes and acks are registered from the next state so each is a clean
  // flop output aligned with the state it belongs to.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_oe_l   <= 1'b1;
      r_we_l   <= 1'b1;
      r_drive  <= 1'b0;
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
    end else begin
      r_oe_l   <= (w_next != ST_RD);
      r_we_l   <= (w_next != ST_WR_PULSE);
      r_drive  <= (w_next == ST_WR_SETUP) || (w_next == ST_WR_PULSE) ||
                  (w_next == ST_WR_HOLD);
      r_if_ack <= (w_next == ST_ACK) && (w_port_next == PORT_IF);
      r_ls_ack <= (w_next == ST_ACK) && (w_port_next == PORT_LS);
    end
  end

  assign sram_data = r_drive ? r_wbuf : 'z;
  assign sram_addr = r_addr;
  assign sram_oe_l = r_oe_l;
  assign sram_we_l = r_we_l;
  assign if_ack    = r_if_ack;
  assign ls_ack    = r_ls_ack;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural asynchronous SRAM on the pins.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        if_req = 1'b0;
  logic [17:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [17:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic [17:0] sram_addr;
  wire logic [31:0] sram_data;
  logic        sram_oe_l;
  logic        sram_we_l;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:65535];
  logic        oe_h  [0:31];
  logic        we_h  [0:31];
  logic        drv_h [0:31];
  logic [31:0] bus_h [0:31];

  always #5 clk = ~clk;

  sram_ctrl #(.RD_CYCLES(2), .WR_CYCLES(2)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ack    (ls_ack),
    .ls_rdata  (ls_rdata),
    .sram_addr (sram_addr),
    .sram_data (sram_data),
    .sram_oe_l (sram_oe_l),
    .sram_we_l (sram_we_l)
  );

  assign sram_data = (!sram_oe_l) ? mem[sram_addr[17:2]] : 'z;

  always @(negedge clk) begin
    if (!sram_we_l) mem[sram_addr[17:2]] <= sram_data;
  end

  always @(negedge clk) begin
    if (rst_l) begin
      checks++;
      assert (!(!sram_oe_l && !sram_we_l)) else begin
        errors++;
        $error("FAIL strobe_overlap: observed oe_l=%b we_l=%b expected not both 0", sram_oe_l, sram_we_l);
      end
      checks++;
      assert (!(if_ack && ls_ack)) else begin
        errors++;
        $error("FAIL dual_ack: observed if_ack=%b ls_ack=%b expected not both 1", if_ack, ls_ack);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance cycle by cycle from the granting IDLE cycle, recording pin history,
  // until an ack appears or the budget runs out (lat = -1).
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int k = 0; k < 32; k++) begin
      oe_h[k] = 1'b1; we_h[k] = 1'b1; drv_h[k] = 1'b0; bus_h[k] = '0;
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      oe_h[k]  = sram_oe_l;
      we_h[k]  = sram_we_l;
      drv_h[k] = dut.r_drive;
      bus_h[k] = sram_data;
      if (if_ack || ls_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int nif;
    int nls;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[21] = 32'h00000004;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe_l", 32'(sram_oe_l), 32'd1);
    chk("rst_we_l", 32'(sram_we_l), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_drive", 32'(dut.r_drive), 32'd0);
    rst_l = 1'b1;
    step();

    // Fetch from word 21
    if_req = 1'b1; if_addr = 18'h00056;
    wait_ack(lat);
    if_req = 1'b0;
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_if_ack", 32'(if_ack), 32'd1);
    chk("rd_ls_ack", 32'(ls_ack), 32'd0);
    chk("rd_if_rdata", if_rdata, 32'h00000004);
    chk("rd_sram_addr", 32'(sram_addr), 32'h00054);
    chk("rd_oe_pattern", {29'd0, oe_h[1], oe_h[2], oe_h[3]}, 32'b001);
    step();

    // Full-word store
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 18'h00100; ls_wdata = 32'hDEADBEEF;
    wait_ack(lat);
    ls_req = 1'b0;
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_ls_ack", 32'(ls_ack), 32'd1);
    chk("wr_we_pattern", {27'd0, we_h[1], we_h[2], we_h[3], we_h[4], we_h[5]}, 32'b10011);
    chk("wr_drive_pattern", {27'd0, drv_h[1], drv_h[2], drv_h[3], drv_h[4], drv_h[5]}, 32'b11110);
    chk("wr_bus_data", bus_h[3], 32'hDEADBEEF);
    chk("wr_mem", mem[64], 32'hDEADBEEF);
    step();

    ls_req = 1'b1; ls_we = 1'b0;
    wait_ack(lat);
    ls_req = 1'b0;
    chk("ld_latency", 32'(lat), 32'd3);
    chk("ld_rdata", ls_rdata, 32'hDEADBEEF);
    step();

    // Partial store -> read-modify-write
    mem[64] = 32'h11223344;
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0101; ls_wdata = 32'hAABBCCDD;
    wait_ack(lat);
    ls_req = 1'b0;
    chk("rmw_latency", 32'(lat), 32'd8);
    chk("rmw_oe_pattern", {29'd0, oe_h[1], oe_h[2], oe_h[3]}, 32'b001);
    chk("rmw_turn_hiz", 32'(drv_h[3]), 32'd0);
    chk("rmw_we_pattern", {29'd0, we_h[5], we_h[6], we_h[7]}, 32'b001);
    chk("rmw_mem", mem[64], 32'h11BB33DD);
    step();

    ls_req = 1'b1; ls_we = 1'b0;
    wait_ack(lat);
    ls_req = 1'b0;
    chk("rmw_readback", ls_rdata, 32'h11BB33DD);
    chk("if_rdata_held", if_rdata, 32'h00000004);
    step();

    // Both ports contending, four transactions each
    if_addr = 18'h00056; ls_addr = 18'h00100; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    nif = 0; nls = 0;
    for (int n = 0; n < 8; n++) begin
      wait_ack(lat);
      chk("arb_latency", 32'(lat), (n == 0) ? 32'd3 : 32'd4);
      chk("arb_order", 32'(ls_ack), ((n % 2) == 0) ? 32'd1 : 32'd0);
      if (ls_ack) begin
        nls++;
        chk("arb_ls_rdata", ls_rdata, 32'h11BB33DD);
        if (nls == 4) ls_req = 1'b0;
      end
      if (if_ack) begin
        nif++;
        chk("arb_if_rdata", if_rdata, 32'h00000004);
        if (nif == 4) if_req = 1'b0;
      end
    end
    chk("arb_if_count", 32'(nif), 32'd4);
    chk("arb_ls_count", 32'(nls), 32'd4);
    step();

    // Store with no byte enables
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h0; ls_wdata = 32'hFFFFFFFF;
    wait_ack(lat);
    ls_req = 1'b0;
    chk("be0_latency", 32'(lat), 32'd1);
    chk("be0_strobes", {30'd0, oe_h[1], we_h[1]}, 32'b11);
    chk("be0_mem", mem[64], 32'h11BB33DD);
    step();

    // Reset during the write pulse
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 18'h00200; ls_wdata = 32'h12345678;
    step();
    step();
    chk("rstw_we_low", 32'(sram_we_l), 32'd0);
    #1;
    rst_l = 1'b0;
    ls_req = 1'b0;
    #1;
    chk("rstw_we_high", 32'(sram_we_l), 32'd1);
    chk("rstw_oe_high", 32'(sram_oe_l), 32'd1);
    chk("rstw_hiz", 32'(dut.r_drive), 32'd0);
    step();
    chk("rstw_no_ack", {30'd0, if_ack, ls_ack}, 32'd0);
    #2;
    rst_l = 1'b1;
    step();
    if_req = 1'b1; if_addr = 18'h00056;
    wait_ack(lat);
    if_req = 1'b0;
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_rdata", if_rdata, 32'h00000004);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Clocked controller that shares the single asynchronous 32-bit SRAM (256 KiB, word-addressed by addr[17:2], active-low oe_l/we_l, bidirectional data) between two requesters.
- Requesters: the core's instruction-fetch port (read-only) and load/store port (read/write with byte enables).
- Arbitrates between the two ports, sequences SRAM strobe timing, and converts partial-word stores into read-modify-write, since the SRAM has no byte enables.
- Sits between the core and the SRAM pins.

Parameters:
- RD_CYCLES, 2, cycles sram_oe_l is held low before read data is sampled (>=1)
- WR_CYCLES, 2, width of the sram_we_l low pulse in cycles (>=1)

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  18  fetch byte address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetch data; valid with if_ack, held until next if_ack
- ls_req  in  1  load/store request; held with fields until ls_ack
- ls_we  in  1  1 = store
- ls_be  in  4  store byte enables, bit i = data[8i+7:8i]
- ls_addr  in  18  load/store byte address
- ls_wdata  in  32  store data
- ls_ack  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data; valid with ls_ack, held until next ls_ack
- sram_addr  out  18  SRAM address; bits [1:0] always 0
- sram_data  inout  32  SRAM data bus; high-Z unless writing
- sram_oe_l  out  1  SRAM output enable, active low
- sram_we_l  out  1  SRAM write enable, active low

Behaviour:
- Reset (async, on rst_l low):
  - state = IDLE; sram_oe_l = 1, sram_we_l = 1, sram_data high-Z.
  - sram_addr, if_rdata, ls_rdata = 0; if_ack, ls_ack = 0; round-robin pointer = ls.
  - Reset asserted mid-transaction drops the transaction immediately, with no ack and strobes high. The requester reissues.
- All SRAM-facing outputs and acks are registered. Requests are sampled only in IDLE.
- Arbitration in IDLE:
  - One requester active: grant it.
  - Both active: grant the port named by the pointer, then point it at the other port.
  - The grant latches address, we, be, wdata and the port ID. sram_addr = {addr[17:2],2'b00}. addr[1:0] is ignored.
- Dispatch from IDLE:
  - Read (fetch, or ls_we = 0) -> RD.
  - Store with be = 4'hF -> WR_SETUP.
  - Store with be = 4'h0 -> ACK, no SRAM activity.
  - Any other store -> RD, with rmw flag set.
- States:
  - RD: sram_oe_l = 0 for RD_CYCLES cycles. sram_data is captured at the last cycle's edge.
    - Plain read: the captured value goes to the owning port's rdata -> ACK.
    - rmw: merge buffer = captured word with bytes replaced where be = 1 -> TURN.
  - TURN: both strobes high, bus high-Z, 1 cycle (read-to-drive turnaround) -> WR_SETUP.
  - WR_SETUP: drive sram_data with the write word (wdata, or the merge buffer for rmw); sram_we_l = 1; 1 cycle.
  - WR_PULSE: sram_we_l = 0 for WR_CYCLES cycles; data keeps driving.
  - WR_HOLD: sram_we_l = 1; data keeps driving; 1 cycle -> ACK.
  - ACK: release the bus; pulse the owning port's ack for 1 cycle -> IDLE.
- Latency, counted from the IDLE cycle t that grants:
  - Read: ack at t+RD_CYCLES+1.
  - Full store: ack at t+WR_CYCLES+3.
  - RMW: ack at t+RD_CYCLES+WR_CYCLES+4 (t+8 at defaults).
  - be = 0 store: ack at t+1.
- Handshake: a requester keeping req high after its ack starts a new transaction, arbitrated in the following IDLE cycle.
- Invariants:
  - sram_oe_l and sram_we_l are never both low.
  - sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD.
  - sram_addr is stable from the first RD/WR_SETUP cycle through WR_HOLD.
  - Only one ack fires per transaction; if_ack and ls_ack are never both high.
- Cycle counter width: clog2 of max(RD_CYCLES, WR_CYCLES)+1.

Decomposition:
- Shared include sram_ctrl_defs.vh holds:
  - state encodings: IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  - SRAM_AW = 18, SRAM_DW = 32
  - port IDs PORT_IF = 0, PORT_LS = 1
- One sub-module, rr_arb2: 2-way round-robin arbiter with req[1:0], an advance strobe, one-hot gnt[1:0], and reset pointer = ls.

Test Plan:
- SRAM word 21 preset to 32'h00000004; if_req, if_addr = 18'h00056 -> at t+3, if_ack = 1, if_rdata = 32'h00000004, sram_addr = 18'h00054; oe_l low exactly cycles t+1 and t+2.
- ls store, addr 18'h00100, be = 4'hF, wdata = 32'hDEADBEEF -> we_l low cycles t+2 and t+3, data driven t+1..t+4, ls_ack at t+5. A subsequent load returns 32'hDEADBEEF.
- Word at 0x100 = 32'h11223344; store be = 4'b0101, wdata = 32'hAABBCCDD -> ls_ack at t+8; read back = 32'h11BB33DD; bus high-Z during TURN; oe_l/we_l never both low.
- if_req and ls_req raised together and held for 4 transactions each -> grants alternate ls, if, ls, if...; each port gets exactly 4 acks, with no gaps beyond one IDLE cycle.
- Store with be = 4'h0 -> ls_ack at t+1; oe_l and we_l stay high; SRAM contents unchanged.
- rst_l pulsed low during WR_PULSE -> we_l goes high and the bus goes high-Z asynchronously; no ack; after release, state is IDLE and a new fetch completes normally.
